// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter, 8N1 frames, LSB first.
// Define UART_TX_PARITY_EN to insert an even parity bit after the data (8E1).
module uart_tx_fifo #(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BAUD_RATE   = 115200,
    parameter int FIFO_DEPTH  = 16,
    parameter int STOP_BITS   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_txd,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int BIT_DIV = CLK_FREQ_HZ / BAUD_RATE;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_DIV - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [7:0]    head_data;
    logic [AW:0]   level_next;

    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          baud_end;
    logic          stop_end;
    logic          going_idle;
`ifdef UART_TX_PARITY_EN
    logic          parity_bit;
`endif

    // The extra pointer MSB separates full (MSBs differ) from empty (equal).
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign tx_ready   = !full;
    assign push       = tx_valid && !full;
    assign fifo_level = wr_ptr - rd_ptr;
    assign head_data  = mem[rd_ptr[AW-1:0]];

    assign baud_end   = (baud_cnt == BAUD_LAST);
    assign stop_end   = (state == STOP) && baud_end && (bit_cnt == STOP_LAST);
    assign pop        = !empty && ((state == IDLE) || stop_end);
    assign going_idle = !pop && ((state == IDLE) || stop_end);
    assign level_next = fifo_level + (AW+1)'(push) - (AW+1)'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= tx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (tx_valid && !tx_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    // Popping at the end of STOP goes straight into START, so queued bytes leave with no gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            uart_txd  <= 1'b1;
            tx_busy   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            tx_busy <= !going_idle || (level_next != '0);
            if (state != IDLE) begin
                baud_cnt <= baud_end ? '0 : baud_cnt + CW'(1);
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift_reg <= head_data;
                        uart_txd  <= 1'b0;
                        state     <= START;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^head_data;
`endif
                    end
                end
                START: begin
                    if (baud_end) begin
                        uart_txd <= shift_reg[0];
                        bit_cnt  <= '0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            uart_txd <= parity_bit;
                            state    <= PARITY;
`else
                            uart_txd <= 1'b1;
                            state    <= STOP;
`endif
                        end else begin
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            uart_txd  <= shift_reg[1];
                            bit_cnt   <= bit_cnt + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_end) begin
                        uart_txd <= 1'b1;
                        state    <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (baud_end) begin
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            if (pop) begin
                                shift_reg <= head_data;
                                uart_txd  <= 1'b0;
                                state     <= START;
`ifdef UART_TX_PARITY_EN
                                parity_bit <= ^head_data;
`endif
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    uart_txd <= 1'b1;
                end
            endcase
        end
    end

endmodule
